// File: rtl/switch_debouncer.sv
// Synchronises and debounces the five raw slide-switch lanes feeding the gate-select mux.
// Also produces a one-cycle change pulse and a settled flag for logging and display logic.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_sw0,
    input  logic       raw_sw1,
    input  logic [2:0] raw_select,
    output logic       sw0,
    output logic       sw1,
    output logic [2:0] select,
    output logic       changed,
    output logic       settled
);

    localparam int LANES = 5;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [LANES-1:0] raw_vec;
    logic [LANES-1:0] s1_reg;
    logic [LANES-1:0] s2_reg;
    logic [LANES-1:0] stable_vec;
    logic [LANES-1:0] stable_next_vec;
    logic [LANES-1:0] update_vec;
    logic             changed_reg;
    logic             settled_reg;
    logic             settled_next;

    assign raw_vec = {raw_select, raw_sw1, raw_sw0};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= raw_vec;
            s2_reg <= s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             stable_reg;
            logic             stable_next;
            logic             update;

            // Any sample matching the accepted level restarts the run count.
            always_comb begin
                cnt_next    = cnt_reg;
                stable_next = stable_reg;
                update      = 1'b0;
                if (s2_reg[gi] == stable_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    stable_next = s2_reg[gi];
                    cnt_next    = '0;
                    update      = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    stable_reg <= stable_next;
                end
            end

            assign stable_vec[gi]      = stable_reg;
            assign stable_next_vec[gi] = stable_next;
            assign update_vec[gi]      = update;
        end
    endgenerate

    // Compare against the post-edge stable value so settled rises together with the output.
    assign settled_next = (s2_reg == stable_next_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_reg <= 1'b0;
            settled_reg <= 1'b1;
        end else begin
            changed_reg <= |update_vec;
            settled_reg <= settled_next;
        end
    end

    assign sw0     = stable_vec[0];
    assign sw1     = stable_vec[1];
    assign select  = stable_vec[4:2];
    assign changed = changed_reg;
    assign settled = settled_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random bouncing, checked every edge
// against a sample-history model (accept a level once the last D synchronized samples all differ).
module tb_switch_debouncer;

    localparam int D    = 4;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_sw0 = 1'b0;
    logic       raw_sw1 = 1'b0;
    logic [2:0] raw_select = 3'b000;
    logic       sw0;
    logic       sw1;
    logic [2:0] select;
    logic       changed;
    logic       settled;

    switch_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_sw0    (raw_sw0),
        .raw_sw1    (raw_sw1),
        .raw_select (raw_select),
        .sw0        (sw0),
        .sw1        (sw1),
        .select     (select),
        .changed    (changed),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ec       = 0;
    int pulse_cnt = 0;
    int unsettled_cnt = 0;

    logic [4:0] rawh [0:MAXC-1];
    bit         rsth [0:MAXC-1];
    logic [4:0] s2a  [0:MAXC-1];
    logic [4:0] stab_m = '0;
    bit         chg_m  = 1'b0;
    bit         set_m  = 1'b1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, ec, obs, exp);
        end
    endtask

    // Synchronized sample seen after edge n: raw from edge n-1, forced 0 around a reset.
    task automatic model_edge(input int n);
        bit all_diff;
        if (n == 0 || rsth[n]) s2a[n] = '0;
        else if (rsth[n-1]) s2a[n] = '0;
        else s2a[n] = rawh[n-1];
        chg_m = 1'b0;
        if (rsth[n]) begin
            stab_m = '0;
            set_m  = 1'b1;
        end else begin
            for (int l = 0; l < 5; l++) begin
                if (n >= D) begin
                    all_diff = 1'b1;
                    for (int j = n - D; j < n; j++)
                        if (s2a[j][l] == stab_m[l]) all_diff = 1'b0;
                    if (all_diff) begin
                        stab_m[l] = ~stab_m[l];
                        chg_m = 1'b1;
                    end
                end
            end
            set_m = (n == 0) ? 1'b1 : (s2a[n-1] == stab_m);
        end
    endtask

    task automatic tick();
        if (ec >= MAXC - 1) begin
            $display("FAIL history_overflow at edge %0d: got %0d, expected < %0d", ec, ec, MAXC - 1);
            $fatal(1, "history overflow");
        end
        @(posedge clk);
        rawh[ec] = {raw_select, raw_sw1, raw_sw0};
        rsth[ec] = rst;
        #1;
        model_edge(ec);
        check("sw0",     {7'd0, sw0},     {7'd0, stab_m[0]});
        check("sw1",     {7'd0, sw1},     {7'd0, stab_m[1]});
        check("select",  {5'd0, select},  {5'd0, stab_m[4:2]});
        check("changed", {7'd0, changed}, {7'd0, chg_m});
        check("settled", {7'd0, settled}, {7'd0, set_m});
        if (changed) pulse_cnt++;
        if (!settled) unsettled_cnt++;
        ec++;
    endtask

    task automatic set_raw(input logic [4:0] v);
        {raw_select, raw_sw1, raw_sw0} = v;
    endtask

    task automatic quiet();
        rst = 1'b0;
        set_raw(5'b00000);
        repeat (12) tick();
        pulse_cnt = 0;
        unsettled_cnt = 0;
    endtask

    initial begin
        // 1: reset with all raw high, then normal debounce after release
        set_raw(5'b11111);
        rst = 1'b1;
        repeat (3) begin
            tick();
            check("rst_outputs", {3'd0, select, sw1, sw0}, 8'd0);
            check("rst_changed", {7'd0, changed}, 8'd0);
            check("rst_settled", {7'd0, settled}, 8'd1);
        end
        pulse_cnt = 0;
        rst = 1'b0;
        repeat (10) tick();
        check("t1_outputs", {3'd0, select, sw1, sw0}, 8'h1f);
        check("t1_pulses", 8'(pulse_cnt), 8'd1);

        // 2: select 000 -> 101 held
        quiet();
        set_raw(5'b10100);
        repeat (10) tick();
        check("t2_select", {5'd0, select}, 8'h05);
        check("t2_pulses", 8'(pulse_cnt), 8'd1);
        check("t2_unsettled", 8'(unsettled_cnt), 8'd3);

        // 3: 3-edge glitch on sw0 is discarded
        quiet();
        set_raw(5'b00001);
        repeat (3) tick();
        set_raw(5'b00000);
        repeat (10) tick();
        check("t3_sw0", {7'd0, sw0}, 8'd0);
        check("t3_pulses", 8'(pulse_cnt), 8'd0);
        check("t3_unsettled", 8'(unsettled_cnt), 8'd3);

        // 4: sw1 bounces then holds high
        quiet();
        for (int i = 0; i < 4; i++) begin
            raw_sw1 = (i % 2 == 0);
            tick();
        end
        raw_sw1 = 1'b1;
        repeat (10) tick();
        check("t4_sw1", {7'd0, sw1}, 8'd1);
        check("t4_pulses", 8'(pulse_cnt), 8'd1);

        // 5: two lanes rising on the same edge give one pulse
        quiet();
        set_raw(5'b00101);
        repeat (10) tick();
        check("t5_outputs", {3'd0, select, sw1, sw0}, 8'h05);
        check("t5_pulses", 8'(pulse_cnt), 8'd1);

        // 6: reset mid-count restarts the debounce
        quiet();
        set_raw(5'b00001);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t6_sw0_rst", {7'd0, sw0}, 8'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("t6_sw0", {7'd0, sw0}, 8'd1);
        check("t6_pulses", 8'(pulse_cnt), 8'd1);

        // Random bouncing on all lanes with occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] v;
            v = {raw_select, raw_sw1, raw_sw0};
            for (int l = 0; l < 5; l++)
                if ($urandom_range(0, 5) == 0) v[l] = ~v[l];
            set_raw(v);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
